// File: rtl/bcd_counter_n.sv
// -----------------------------------------------------------------------------
// bcd_counter_n
//
// Parameterised up/down BCD counter that counts over 0..LIMIT inclusive.
// Loads are range-checked, and a terminal-count pulse is raised on wrap/reload.
//
// Parameter
//   DIGITS    number of BCD digits (1..8); W = 4*DIGITS
//
// Ports
//   CLK       rising-edge clock
//   RESET     asynchronous, active-low reset (clears Q, TC and ERR)
//   CLR       synchronous clear, highest synchronous priority
//   LOAD      synchronous load of LOAD_VAL (rejected if it is not BCD or > LIMIT)
//   LOAD_VAL  [W] BCD value to load
//   EN        count enable
//   UP_DN     count direction, 1 = up, 0 = down
//   LIMIT     [W] BCD terminal value, sampled every cycle
//   Q         [W] registered BCD count, digit 0 in Q[3:0]
//   TC        registered one-cycle terminal-count pulse
//   ERR       registered one-cycle pulse for a rejected load
//
// Priority on a clock edge: CLR > LOAD > EN count > hold.
// -----------------------------------------------------------------------------
module bcd_counter_n #(
   parameter int DIGITS = 2
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  CLR,
   input  logic                  LOAD,
   input  logic [4*DIGITS-1:0]   LOAD_VAL,
   input  logic                  EN,
   input  logic                  UP_DN,
   input  logic [4*DIGITS-1:0]   LIMIT,
   output logic [4*DIGITS-1:0]   Q,
   output logic                  TC,
   output logic                  ERR
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0] q_inc;
   logic [W-1:0] q_dec;
   logic         inc_carry;
   logic         dec_borrow;
   logic         load_is_bcd;
   logic         load_ok;

   logic [W-1:0] q_nxt;
   logic         tc_nxt;
   logic         err_nxt;

   // BCD increment: ripple a carry from digit 0 upward; a 9 rolls to 0.
   always_comb begin
      q_inc     = Q;
      inc_carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (inc_carry) begin
            if (Q[4*i +: 4] == 4'd9) begin
               q_inc[4*i +: 4] = 4'd0;
            end else begin
               q_inc[4*i +: 4] = Q[4*i +: 4] + 4'd1;
               inc_carry       = 1'b0;
            end
         end
      end
   end

   // BCD decrement: ripple a borrow from digit 0 upward; a 0 rolls to 9.
   always_comb begin
      q_dec      = Q;
      dec_borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (dec_borrow) begin
            if (Q[4*i +: 4] == 4'd0) begin
               q_dec[4*i +: 4] = 4'd9;
            end else begin
               q_dec[4*i +: 4] = Q[4*i +: 4] - 4'd1;
               dec_borrow      = 1'b0;
            end
         end
      end
   end

   always_comb begin
      load_is_bcd = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (LOAD_VAL[4*i +: 4] > 4'd9) begin
            load_is_bcd = 1'b0;
         end
      end
   end

   // For valid BCD operands the packed binary compare orders values exactly
   // like the decimal compare, so no conversion is needed.
   assign load_ok = load_is_bcd && (LOAD_VAL <= LIMIT);

   always_comb begin
      q_nxt   = Q;
      tc_nxt  = 1'b0;
      err_nxt = 1'b0;
      if (CLR) begin
         q_nxt = '0;
      end else if (LOAD) begin
         if (load_ok) begin
            q_nxt = LOAD_VAL;
         end else begin
            err_nxt = 1'b1;
         end
      end else if (EN) begin
         if (UP_DN) begin
            // Q >= LIMIT also catches a Q stranded above a lowered LIMIT.
            if (Q >= LIMIT) begin
               q_nxt  = '0;
               tc_nxt = 1'b1;
            end else begin
               q_nxt = q_inc;
            end
         end else begin
            if ((Q == '0) || (Q > LIMIT)) begin
               q_nxt  = LIMIT;
               tc_nxt = 1'b1;
            end else begin
               q_nxt = q_dec;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         Q   <= '0;
         TC  <= 1'b0;
         ERR <= 1'b0;
      end else begin
         Q   <= q_nxt;
         TC  <= tc_nxt;
         ERR <= err_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_counter_n.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter_n
//
// Drives a 2-digit and a 4-digit counter from the same stimulus (the 2-digit
// instance sees the low byte of LOAD_VAL and LIMIT). A decimal-integer model
// per instance predicts Q/TC/ERR every cycle; directed sections pin known
// values with literals, then a randomized run exercises everything together.
// -----------------------------------------------------------------------------
module tb_bcd_counter_n;

   // ---------------------------------------------------------------- clock/reset
   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        CLR = 1'b0;
   logic        LOAD = 1'b0;
   logic        EN = 1'b0;
   logic        UP_DN = 1'b0;
   logic [15:0] LOAD_VAL = '0;
   logic [15:0] LIMIT = '0;

   always #5 CLK = ~CLK;

   logic [7:0]  q2;
   logic        tc2, err2;
   logic [15:0] q4;
   logic        tc4, err4;

   bcd_counter_n #(.DIGITS(2)) u_dut2 (
      .CLK      (CLK),
      .RESET    (RESET),
      .CLR      (CLR),
      .LOAD     (LOAD),
      .LOAD_VAL (LOAD_VAL[7:0]),
      .EN       (EN),
      .UP_DN    (UP_DN),
      .LIMIT    (LIMIT[7:0]),
      .Q        (q2),
      .TC       (tc2),
      .ERR      (err2)
   );

   bcd_counter_n #(.DIGITS(4)) u_dut4 (
      .CLK      (CLK),
      .RESET    (RESET),
      .CLR      (CLR),
      .LOAD     (LOAD),
      .LOAD_VAL (LOAD_VAL),
      .EN       (EN),
      .UP_DN    (UP_DN),
      .LIMIT    (LIMIT),
      .Q        (q4),
      .TC       (tc4),
      .ERR      (err4)
   );

   // ---------------------------------------------------------------- bookkeeping
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   // Each instance is modelled as a plain decimal integer.
   int m_q[2];
   bit m_tc[2];
   bit m_err[2];

   function automatic int ndig(input int k);
      return (k == 0) ? 2 : 4;
   endfunction

   function automatic int bcd2int(input logic [15:0] v, input int nd);
      int r = 0;
      int p = 1;
      for (int i = 0; i < nd; i++) begin
         r += int'(v[4*i +: 4]) * p;
         p *= 10;
      end
      return r;
   endfunction

   function automatic bit bcd_ok(input logic [15:0] v, input int nd);
      for (int i = 0; i < nd; i++) begin
         if (v[4*i +: 4] > 4'd9) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [15:0] int2bcd(input int x, input int nd);
      logic [15:0] r = '0;
      int          y = x;
      for (int i = 0; i < nd; i++) begin
         r[4*i +: 4] = 4'(y % 10);
         y = y / 10;
      end
      return r;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         m_q[k]   = 0;
         m_tc[k]  = 1'b0;
         m_err[k] = 1'b0;
      end
   endtask

   task automatic model_step(input int k);
      int nd  = ndig(k);
      int lim = bcd2int(LIMIT, nd);
      int lv  = bcd2int(LOAD_VAL, nd);
      m_tc[k]  = 1'b0;
      m_err[k] = 1'b0;
      if (CLR) begin
         m_q[k] = 0;
      end else if (LOAD) begin
         if (bcd_ok(LOAD_VAL, nd) && lv <= lim) m_q[k] = lv;
         else m_err[k] = 1'b1;
      end else if (EN) begin
         if (UP_DN) begin
            if (m_q[k] >= lim) begin
               m_q[k]  = 0;
               m_tc[k] = 1'b1;
            end else begin
               m_q[k] = m_q[k] + 1;
            end
         end else begin
            if (m_q[k] == 0 || m_q[k] > lim) begin
               m_q[k]  = lim;
               m_tc[k] = 1'b1;
            end else begin
               m_q[k] = m_q[k] - 1;
            end
         end
      end
   endtask

   always @(negedge RESET) model_clear();

   // ---------------------------------------------------------------- scoreboard
   // Entry layout: {tc, err, q[15:0]}
   logic [17:0] exp_q[$];

   initial begin
      logic [17:0] e;
      forever begin
         @(posedge CLK);
         for (int k = 0; k < 2; k++) begin
            if (RESET === 1'b1) model_step(k);
            else model_clear();
            exp_q.push_back({m_tc[k], m_err[k], int2bcd(m_q[k], ndig(k))});
         end
         #1;
         e = exp_q.pop_front();
         check("q2",   {8'h00, q2},   e[15:0]);
         check("tc2",  {15'h0, tc2},  {15'h0, e[17]});
         check("err2", {15'h0, err2}, {15'h0, e[16]});
         e = exp_q.pop_front();
         check("q4",   q4,            e[15:0]);
         check("tc4",  {15'h0, tc4},  {15'h0, e[17]});
         check("err4", {15'h0, err4}, {15'h0, e[16]});
      end
   end

   // ---------------------------------------------------------------- drivers
   task automatic cyc(input bit clr, input bit load, input logic [15:0] lv,
                      input bit en, input bit up, input logic [15:0] lim);
      @(negedge CLK);
      CLR      = clr;
      LOAD     = load;
      LOAD_VAL = lv;
      EN       = en;
      UP_DN    = up;
      LIMIT    = lim;
      @(posedge CLK);
      #2;
   endtask

   // Short reset pulse that sits entirely between two rising edges.
   task automatic pulse_reset();
      @(negedge CLK);
      #2 RESET = 1'b0;
      #1;
      check("rst_q2",  {8'h00, q2}, 16'h0000);
      check("rst_q4",  q4, 16'h0000);
      check("rst_tc",  {14'h0, tc2, tc4}, 16'h0000);
      check("rst_err", {14'h0, err2, err4}, 16'h0000);
      #1 RESET = 1'b1;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      repeat (2) @(negedge CLK);
      check("reset_q2",   {8'h00, q2}, 16'h0000);
      check("reset_tc2",  {15'h0, tc2}, 16'h0000);
      check("reset_err2", {15'h0, err2}, 16'h0000);
      RESET = 1'b1;

      // Up-count over 0..59 from reset.
      for (int e = 1; e <= 61; e++) begin
         cyc(0, 0, 16'h0000, 1, 1, 16'h0059);
         if (e == 59) begin
            check("up59_q",  {8'h00, q2}, 16'h0059);
            check("up59_tc", {15'h0, tc2}, 16'h0000);
         end
         if (e == 60) begin
            check("wrap_q",  {8'h00, q2}, 16'h0000);
            check("wrap_tc", {15'h0, tc2}, 16'h0001);
         end
         if (e == 61) begin
            check("post_q",  {8'h00, q2}, 16'h0001);
            check("post_tc", {15'h0, tc2}, 16'h0000);
         end
      end

      // Down-count from 10 through 0 and reload of LIMIT.
      cyc(0, 1, 16'h0010, 0, 0, 16'h0059);
      cyc(0, 0, 16'h0000, 1, 0, 16'h0059);
      check("dn_09", {8'h00, q2}, 16'h0009);
      repeat (9) cyc(0, 0, 16'h0000, 1, 0, 16'h0059);
      check("dn_00", {8'h00, q2}, 16'h0000);
      cyc(0, 0, 16'h0000, 1, 0, 16'h0059);
      check("dn_reload_q",  {8'h00, q2}, 16'h0059);
      check("dn_reload_tc", {15'h0, tc2}, 16'h0001);

      // Load acceptance and rejection.
      cyc(0, 1, 16'h003A, 0, 0, 16'h0059);
      check("ld3a_err", {15'h0, err2}, 16'h0001);
      check("ld3a_q",   {8'h00, q2}, 16'h0059);
      cyc(0, 1, 16'h0060, 0, 0, 16'h0059);
      check("ld60_err", {15'h0, err2}, 16'h0001);
      check("ld60_q",   {8'h00, q2}, 16'h0059);
      cyc(0, 1, 16'h0042, 0, 0, 16'h0059);
      check("ld42_err", {15'h0, err2}, 16'h0000);
      check("ld42_q",   {8'h00, q2}, 16'h0042);

      // CLR beats LOAD and EN.
      cyc(1, 1, 16'h0042, 1, 1, 16'h0059);
      check("clr_q",   {8'h00, q2}, 16'h0000);
      check("clr_tc",  {15'h0, tc2}, 16'h0000);
      check("clr_err", {15'h0, err2}, 16'h0000);

      // LIMIT lowered below Q.
      cyc(0, 1, 16'h0045, 0, 1, 16'h0059);
      cyc(0, 0, 16'h0000, 1, 1, 16'h0030);
      check("lowlim_q",  {8'h00, q2}, 16'h0000);
      check("lowlim_tc", {15'h0, tc2}, 16'h0001);

      // LIMIT = 0 in both directions.
      cyc(0, 0, 16'h0000, 1, 1, 16'h0000);
      check("lim0_up_q",  {8'h00, q2}, 16'h0000);
      check("lim0_up_tc", {15'h0, tc2}, 16'h0001);
      cyc(0, 0, 16'h0000, 1, 0, 16'h0000);
      check("lim0_dn_q",  {8'h00, q2}, 16'h0000);
      check("lim0_dn_tc", {15'h0, tc2}, 16'h0001);

      // Four-digit carry/borrow and mid-cycle reset.
      cyc(0, 1, 16'h0200, 0, 0, 16'h9999);
      cyc(0, 0, 16'h0000, 1, 0, 16'h9999);
      check("d4_borrow", q4, 16'h0199);
      cyc(0, 1, 16'h0999, 0, 1, 16'h9999);
      cyc(0, 0, 16'h0000, 1, 1, 16'h9999);
      check("d4_carry", q4, 16'h1000);
      pulse_reset();

      // Randomized run.
      for (int n = 0; n < 3000; n++) begin
         @(negedge CLK);
         CLR      = ($urandom_range(0, 99) < 3);
         LOAD     = ($urandom_range(0, 9) == 0);
         LOAD_VAL = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                : int2bcd($urandom_range(0, 9999), 4);
         EN       = ($urandom_range(0, 9) < 7);
         UP_DN    = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 49) == 0) begin
            case ($urandom_range(0, 2))
               0:       LIMIT = 16'h0000;
               1:       LIMIT = int2bcd($urandom_range(0, 30), 4);
               default: LIMIT = int2bcd($urandom_range(0, 9999), 4);
            endcase
         end
         if (n % 500 == 250) pulse_reset();
      end

      repeat (2) @(negedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_counter_n.md
BCD_COUNTER_N -- requirements
Module: bcd_counter_n

Interface
REQ-001 Parameter: DIGITS, default 2, number of BCD digits (range 1..8); W = 4*DIGITS.
REQ-002 Port: CLK  input  1  rising-edge clock.
REQ-003 Port: RESET  input  1  asynchronous, active-low reset.
REQ-004 Port: CLR  input  1  synchronous clear to zero, highest synchronous priority.
REQ-005 Port: LOAD  input  1  synchronous load of LOAD_VAL.
REQ-006 Port: LOAD_VAL  input  W  BCD value to load.
REQ-007 Port: EN  input  1  count enable.
REQ-008 Port: UP_DN  input  1  count direction, 1 = up, 0 = down.
REQ-009 Port: LIMIT  input  W  BCD terminal value; count range is 0..LIMIT inclusive.
REQ-010 Port: Q  output  W  registered BCD count; digit 0 = Q[3:0], least significant.
REQ-011 Port: TC  output  1  registered terminal-count pulse.
REQ-012 Port: ERR  output  1  registered error pulse for a rejected load.

Function
REQ-013 All outputs SHALL be registered and update only on a CLK rising edge or on RESET assertion.
REQ-014 Synchronous priority SHALL be CLR > LOAD > (EN count) > hold.
REQ-015 CLR=1: Q SHALL become 0, TC=0, ERR=0.
REQ-016 LOAD=1 with every LOAD_VAL digit <= 9 and LOAD_VAL <= LIMIT (decimal compare): Q SHALL become LOAD_VAL, TC=0, ERR=0.
REQ-017 LOAD=1 with any LOAD_VAL digit > 9, or LOAD_VAL > LIMIT: the load SHALL be rejected, Q SHALL hold, TC=0, ERR=1 for exactly that cycle.
REQ-018 EN=1, UP_DN=1, Q >= LIMIT: Q SHALL wrap to 0 and TC SHALL be 1 for one cycle.
REQ-019 EN=1, UP_DN=1, Q < LIMIT: Q SHALL increment by one in BCD; a digit at 9 becomes 0 and carries into the next digit (e.g. 0x0199 -> 0x0200).
REQ-020 EN=1, UP_DN=0, Q == 0 or Q > LIMIT: Q SHALL load LIMIT and TC SHALL be 1 for one cycle.
REQ-021 EN=1, UP_DN=0, 0 < Q <= LIMIT: Q SHALL decrement by one in BCD; a digit at 0 becomes 9 and borrows from the next digit (e.g. 0x0200 -> 0x0199).
REQ-022 EN=0 with no CLR/LOAD: Q SHALL hold, TC=0, ERR=0.
REQ-023 TC and ERR SHALL be 0 in every cycle not named in REQ-017, REQ-018 or REQ-020; neither output is sticky.
REQ-024 LIMIT SHALL be sampled combinationally each cycle; a change to LIMIT takes effect at the next count edge with no latency.
REQ-025 If LIMIT is lowered below Q, the next up-count SHALL wrap to 0 (REQ-018) and the next down-count SHALL load LIMIT (REQ-020).
REQ-026 Behaviour for LIMIT containing a digit > 9 is unspecified; ERR is not required to flag it.
REQ-027 Q SHALL always hold valid BCD (every digit <= 9) when LIMIT is valid BCD.
REQ-028 LIMIT = 0: up-count and down-count SHALL both keep Q = 0 and assert TC on every enabled cycle.
REQ-029 UP_DN may change on any cycle; the direction sampled at the edge SHALL decide that edge's update.

Reset
REQ-030 RESET=0 SHALL immediately force Q=0, TC=0, ERR=0, independent of CLK, including mid-count.
REQ-031 While RESET=0, all synchronous inputs SHALL be ignored.
REQ-032 After RESET deasserts, the first rising CLK edge SHALL apply REQ-014 normally.

Verification (DIGITS=2 unless stated)
REQ-033 LIMIT=0x59, EN=1, UP_DN=1, 61 edges from reset -> Q counts 0x00..0x59 with no non-BCD value; at edge 60 Q=0x00 and TC=1 for that one cycle only.
REQ-034 LIMIT=0x59, Q=0x10, UP_DN=0, EN=1 -> Q=0x09, then 0x08 ... 0x00; next edge Q=0x59 and TC=1.
REQ-035 LIMIT=0x59: LOAD_VAL=0x3A -> ERR=1 and Q held; LOAD_VAL=0x60 -> ERR=1 and Q held; LOAD_VAL=0x42 -> Q=0x42 and ERR=0.
REQ-036 CLR=1, LOAD=1, EN=1 on the same edge -> Q=0x00, TC=0, ERR=0.
REQ-037 Q=0x45 while counting, LIMIT changed to 0x30, UP_DN=1 -> next edge Q=0x00 and TC=1.
REQ-038 DIGITS=4, LIMIT=0x9999, Q=0x0999, up one edge -> Q=0x1000; RESET pulsed low between edges -> Q=0x0000 before the next edge.
